// File: rtl/mode7_scan_pkg.sv
// Shared VGA timing defaults and colour field positions for the Mode 7 scan generator.
package mode7_scan_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam int unsigned ANGLE_MOD = 360;

    // rgb332 slices of the texel byte
    localparam int unsigned RED_HI   = 7;
    localparam int unsigned RED_LO   = 5;
    localparam int unsigned GREEN_HI = 4;
    localparam int unsigned GREEN_LO = 2;
    localparam int unsigned BLUE_HI  = 1;
    localparam int unsigned BLUE_LO  = 0;

endpackage

// File: rtl/mode7_delay_line.sv
// Enable-gated shift register with synchronous reset value; DEPTH = 0 is a plain wire.
module mode7_delay_line #(
    parameter int unsigned         WIDTH     = 1,
    parameter int unsigned         DEPTH     = 1,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, en};
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else if (en) begin
                    stage_q[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mode7_scan_gen.sv
// Raster coordinate generator and latency-aligned VGA back end for the Mode 7 datapath.
// Define MODE7_ANGLE_STEP_EN to advance the rotation angle by ANGLE_STEP once per frame.
module mode7_scan_gen
    import mode7_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter int unsigned COLOR_LAT   = 1,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned ANGLE_STEP  = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] x,
    output logic [15:0] y,
    input  logic [7:0]  color,
    output logic [9:0]  angle,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q;
    logic [15:0]      hcount_q, vcount_q;
    logic             h_last, v_last, frame_wrap;
    logic             frame_start_q;
    logic             hs_q, vs_q, on_q;
    logic [2:0]       red_q, green_q;
    logic [1:0]       blue_q;
    logic [2:0]       raw_timing, aligned_timing;

    assign div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    assign h_last     = (hcount_q == 16'(H_TOTAL - 1));
    assign v_last     = (vcount_q == 16'(V_TOTAL - 1));
    assign frame_wrap = tick_q && h_last && v_last;

    // {hsync, vsync, on} decoded from the coordinates being issued this tick
    always_comb begin
        raw_timing[2] = (hcount_q >= 16'(HS_START) && hcount_q <= 16'(HS_END)) ?
                        SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw_timing[1] = (vcount_q >= 16'(VS_START) && vcount_q <= 16'(VS_END)) ?
                        SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw_timing[0] = (hcount_q < 16'(H_VISIBLE)) && (vcount_q < 16'(V_VISIBLE));
    end

    mode7_delay_line #(
        .WIDTH     (3),
        .DEPTH     (COLOR_LAT),
        .RESET_VAL ({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0})
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .en    (tick_q),
        .din   (raw_timing),
        .dout  (aligned_timing)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            tick_q        <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            hs_q          <= ~SYNC_ACTIVE;
            vs_q          <= ~SYNC_ACTIVE;
            on_q          <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            div_q         <= div_d;
            tick_q        <= (div_d == DIV_LAST);
            frame_start_q <= frame_wrap;
            if (tick_q) begin
                hcount_q <= h_last ? '0 : hcount_q + 16'd1;
                if (h_last) begin
                    vcount_q <= v_last ? '0 : vcount_q + 16'd1;
                end
                hs_q    <= aligned_timing[2];
                vs_q    <= aligned_timing[1];
                on_q    <= aligned_timing[0];
                red_q   <= aligned_timing[0] ? color[RED_HI:RED_LO]     : '0;
                green_q <= aligned_timing[0] ? color[GREEN_HI:GREEN_LO] : '0;
                blue_q  <= aligned_timing[0] ? color[BLUE_HI:BLUE_LO]   : '0;
            end
        end
    end

`ifdef MODE7_ANGLE_STEP_EN
    logic [9:0]  angle_q;
    logic [10:0] angle_sum;

    always_comb begin
        angle_sum = {1'b0, angle_q} + 11'(ANGLE_STEP);
        if (angle_sum >= 11'(ANGLE_MOD)) begin
            angle_sum = angle_sum - 11'(ANGLE_MOD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            angle_q <= '0;
        end else if (frame_wrap) begin
            angle_q <= angle_sum[9:0];
        end
    end

    assign angle = angle_q;
`else
    assign angle = '0;
`endif

    assign x           = hcount_q;
    assign y           = vcount_q;
    assign pixel_tick  = tick_q;
    assign frame_start = frame_start_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = on_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule
